// File: rtl/sprite_pkg.sv
`default_nettype none
// =============================================================================
// Module      : sprite_pkg
// Description : Shared encodings for the sprite attribute unit.
// Revision    : 1.0
// =============================================================================
package sprite_pkg;

    typedef enum logic [1:0] {
        SPR_X     = 2'd0,
        SPR_Y     = 2'd1,
        SPR_IMG   = 2'd2,
        SPR_FLAGS = 2'd3
    } spr_field_e;

    typedef enum logic [1:0] {
        SPR_SET  = 2'd0,
        SPR_ADD  = 2'd1,
        SPR_OR   = 2'd2,
        SPR_ANDN = 2'd3
    } spr_op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_UPD  = 1'b1
    } spr_state_e;

    // Bit positions inside the FLAGS field
    localparam int c_FLAG_ENABLE   = 0;
    localparam int c_FLAG_HFLIP    = 1;
    localparam int c_FLAG_VFLIP    = 2;
    localparam int c_FLAG_PRIORITY = 3;

endpackage
`default_nettype wire

// File: rtl/sprite_alu.sv
`default_nettype none
// =============================================================================
// Module      : sprite_alu
// Description : Combinational SET/ADD/OR/ANDN on one attribute field.
// Revision    : 1.0
// =============================================================================
module sprite_alu
    import sprite_pkg::*;
#(
    parameter int FIELD_W = 8
) (
    input  spr_op_e              op,
    input  logic [FIELD_W-1:0]   field_val,
    input  logic [FIELD_W-1:0]   operand,
    output logic [FIELD_W-1:0]   result,
    output logic                 sat
);

    // Unsigned field plus signed delta, two guard bits to see both overflow directions
    logic [FIELD_W+1:0] w_sum;

    assign w_sum = {2'b00, field_val} + {{2{operand[FIELD_W-1]}}, operand};

    always_comb begin
        result = operand;
        sat    = 1'b0;
        case (op)
            SPR_SET:  result = operand;
            SPR_ADD: begin
                if (w_sum[FIELD_W+1]) begin
                    result = '0;
                    sat    = 1'b1;
                end else if (w_sum[FIELD_W]) begin
                    result = '1;
                    sat    = 1'b1;
                end else begin
                    result = w_sum[FIELD_W-1:0];
                end
            end
            SPR_OR:   result = field_val | operand;
            SPR_ANDN: result = field_val & ~operand;
            default:  result = operand;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sprite_unit.sv
`default_nettype none
// =============================================================================
// Module      : sprite_unit
// Description : Sprite attribute store with read, SET and two-cycle RMW updates.
// Revision    : 1.0
// =============================================================================
module sprite_unit
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 256,
    parameter int FIELD_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           sprite_action,
    input  logic [7:0]           sprite_addr,
    input  logic [FIELD_W-1:0]   sprite_write_data,
    input  logic                 sprite_re,
    input  logic                 sprite_we,
    output logic                 sprite_stall,
    output logic [31:0]          sprite_data,
    output logic                 sprite_data_valid,
    output logic                 sprite_sat,
    output logic                 sprite_err,
    input  logic [7:0]           disp_addr,
    output logic [4*FIELD_W-1:0] disp_attr
);

    logic [FIELD_W-1:0] r_attr [NUM_SPRITES][4];

    spr_state_e         r_state;
    logic [FIELD_W-1:0] r_hold_val;
    logic [FIELD_W-1:0] r_hold_opnd;
    logic [7:0]         r_hold_addr;
    logic [1:0]         r_hold_field;
    spr_op_e            r_hold_op;

    logic [31:0]          r_data;
    logic                 r_valid;
    logic                 r_sat;
    logic                 r_err;
    logic [4*FIELD_W-1:0] r_disp;

    logic               w_accept;
    spr_op_e            w_op;
    logic [1:0]         w_field;
    logic [FIELD_W-1:0] w_cur;
    logic [FIELD_W-1:0] w_alu_res;
    logic               w_alu_sat;

    assign w_op     = spr_op_e'(sprite_action[3:2]);
    assign w_field  = sprite_action[1:0];
    assign w_cur    = r_attr[sprite_addr][w_field];
    assign w_accept = (sprite_re | sprite_we) & (r_state == ST_IDLE);

    sprite_alu #(
        .FIELD_W   (FIELD_W)
    ) u_alu (
        .op        (r_hold_op),
        .field_val (r_hold_val),
        .operand   (r_hold_opnd),
        .result    (w_alu_res),
        .sat       (w_alu_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SPRITES; s++) begin
                for (int f = 0; f < 4; f++) begin
                    r_attr[s][f] <= '0;
                end
            end
            r_state      <= ST_IDLE;
            r_hold_val   <= '0;
            r_hold_opnd  <= '0;
            r_hold_addr  <= '0;
            r_hold_field <= '0;
            r_hold_op    <= SPR_SET;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_sat        <= 1'b0;
            r_err        <= 1'b0;
            r_disp       <= '0;
        end else begin
            r_valid <= 1'b0;
            r_sat   <= 1'b0;
            r_err   <= 1'b0;
            // Sampled before any same-edge write lands, so it shows the old entry
            r_disp  <= {r_attr[disp_addr][3], r_attr[disp_addr][2],
                        r_attr[disp_addr][1], r_attr[disp_addr][0]};
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (sprite_we) begin
                            r_err <= sprite_re;
                            if (w_op == SPR_SET) begin
                                r_attr[sprite_addr][w_field] <= sprite_write_data;
                            end else begin
                                r_hold_val   <= w_cur;
                                r_hold_opnd  <= sprite_write_data;
                                r_hold_addr  <= sprite_addr;
                                r_hold_field <= w_field;
                                r_hold_op    <= w_op;
                                r_state      <= ST_UPD;
                            end
                        end else begin
                            r_data  <= {{(32-FIELD_W){1'b0}}, w_cur};
                            r_valid <= 1'b1;
                        end
                    end
                end
                ST_UPD: begin
                    r_attr[r_hold_addr][r_hold_field] <= w_alu_res;
                    r_sat   <= w_alu_sat;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign sprite_stall      = (r_state == ST_UPD);
    assign sprite_data       = r_data;
    assign sprite_data_valid = r_valid;
    assign sprite_sat        = r_sat;
    assign sprite_err        = r_err;
    assign disp_attr         = r_disp;

endmodule
`default_nettype wire
